// File: rtl/fitness_wb_collector.sv
`default_nettype none
// ============================================================================
//  Module      : fitness_wb_collector
//  Description : Collects evaluated energies into a per-index fitness register
//                file, tracks the generation's minimum-energy individual,
//                counts distinct write-backs and flags generation completion.
//                A registered, write-first read port serves the selection
//                stage.
//  Revision    : 1.0  initial release
// ============================================================================
module fitness_wb_collector #(
    parameter int SELF_FIT_LENGTH   = 10,
    parameter int INDIVIDUAL_LENGTH = 22,
    parameter int POP_SIZE          = 50,
    parameter int IDX_WIDTH         = 8,
    parameter int CNT_WIDTH         = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_n,
    input  logic                         gen_start_i,
    input  logic                         in_valid_i,
    input  logic [SELF_FIT_LENGTH-1:0]   total_energy_i,
    input  logic [INDIVIDUAL_LENGTH-1:0] individual_vec_i,
    input  logic [IDX_WIDTH-1:0]         ind_idx_i,
    input  logic [IDX_WIDTH-1:0]         rd_idx_i,
    output logic [SELF_FIT_LENGTH-1:0]   rd_fit_ff_o,
    output logic [SELF_FIT_LENGTH-1:0]   best_energy_ff_o,
    output logic [INDIVIDUAL_LENGTH-1:0] best_vec_ff_o,
    output logic [IDX_WIDTH-1:0]         best_idx_ff_o,
    output logic [CNT_WIDTH-1:0]         wb_cnt_ff_o,
    output logic                         gen_done_ff_o,
    output logic                         busy_ff_o,
    output logic                         dup_err_ff_o,
    output logic                         range_err_ff_o
);

    // Address width of the register file (at least one bit).
    localparam int                         ADDR_W    = (POP_SIZE > 1) ? $clog2(POP_SIZE) : 1;
    // Index bound widened to 32 bits so the range compare sees every index bit.
    localparam logic [31:0]                POP_LIMIT = 32'(POP_SIZE);
    localparam logic [CNT_WIDTH-1:0]       POP_CNT   = CNT_WIDTH'(POP_SIZE);
    localparam logic [SELF_FIT_LENGTH-1:0] FIT_ONES  = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                       state;
    logic [POP_SIZE-1:0]          valid_map;
    logic [SELF_FIT_LENGTH-1:0]   fit_rf [POP_SIZE];

    logic                         wr_in_range;
    logic                         rd_in_range;
    logic [ADDR_W-1:0]            wr_addr;
    logic [ADDR_W-1:0]            rd_addr;
    logic                         accept;
    logic                         wr_en;
    logic                         is_dup;
    logic                         is_better;
    logic [CNT_WIDTH-1:0]         cnt_next;

    // Decode of the incoming sample; a simultaneous gen_start drops it.
    always_comb begin
        wr_in_range = (32'(ind_idx_i) < POP_LIMIT);
        rd_in_range = (32'(rd_idx_i) < POP_LIMIT);
        wr_addr     = ind_idx_i[ADDR_W-1:0];
        rd_addr     = rd_idx_i[ADDR_W-1:0];
        accept      = (state == ST_COLLECT) && in_valid_i && !gen_start_i;
        wr_en       = accept && wr_in_range;
        is_dup      = wr_in_range && valid_map[wr_addr];
        is_better   = (total_energy_i < best_energy_ff_o);
        cnt_next    = wb_cnt_ff_o + CNT_WIDTH'(1);
    end

    // Generation FSM, bitmap, counter, error flags and best-individual tracking.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            valid_map        <= '0;
            wb_cnt_ff_o      <= '0;
            gen_done_ff_o    <= 1'b0;
            busy_ff_o        <= 1'b0;
            dup_err_ff_o     <= 1'b0;
            range_err_ff_o   <= 1'b0;
            best_energy_ff_o <= FIT_ONES;
            best_vec_ff_o    <= '0;
            best_idx_ff_o    <= '0;
        end else begin
            gen_done_ff_o <= 1'b0;
            if (gen_start_i) begin
                state            <= ST_COLLECT;
                busy_ff_o        <= 1'b1;
                valid_map        <= '0;
                wb_cnt_ff_o      <= '0;
                dup_err_ff_o     <= 1'b0;
                range_err_ff_o   <= 1'b0;
                best_energy_ff_o <= FIT_ONES;
                best_vec_ff_o    <= '0;
                best_idx_ff_o    <= '0;
            end else if (accept) begin
                if (!wr_in_range) begin
                    // Out-of-range sample: flagged and otherwise discarded.
                    range_err_ff_o <= 1'b1;
                end else begin
                    if (is_dup) begin
                        dup_err_ff_o <= 1'b1;
                    end else begin
                        valid_map[wr_addr] <= 1'b1;
                        wb_cnt_ff_o        <= cnt_next;
                        if (cnt_next == POP_CNT) begin
                            state         <= ST_DONE;
                            busy_ff_o     <= 1'b0;
                            gen_done_ff_o <= 1'b1;
                        end
                    end
                    // Strict less-than keeps the earlier individual on ties.
                    if (is_better) begin
                        best_energy_ff_o <= total_energy_i;
                        best_vec_ff_o    <= individual_vec_i;
                        best_idx_ff_o    <= ind_idx_i;
                    end
                end
            end
        end
    end

    // Fitness register file with a registered, write-first read port.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < POP_SIZE; k++) begin
                fit_rf[k] <= '0;
            end
            rd_fit_ff_o <= '0;
        end else begin
            if (wr_en) begin
                fit_rf[wr_addr] <= total_energy_i;
            end
            if (!rd_in_range) begin
                rd_fit_ff_o <= FIT_ONES;
            end else if (wr_en && (rd_addr == wr_addr)) begin
                rd_fit_ff_o <= total_energy_i;
            end else begin
                rd_fit_ff_o <= fit_rf[rd_addr];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fitness_wb_collector.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_fitness_wb_collector
//  Description : Self-checking bench for fitness_wb_collector. Read-port
//                results are predicted from a reference model and queued;
//                a monitor pops and compares them as the DUT produces them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fitness_wb_collector;

    localparam int FW  = 10;
    localparam int VW  = 22;
    localparam int POP = 50;
    localparam int IW  = 8;
    localparam int CW  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          gen_start = 1'b0;
    logic          in_valid = 1'b0;
    logic [FW-1:0] energy = '0;
    logic [VW-1:0] vec = '0;
    logic [IW-1:0] idx = '0;
    logic [IW-1:0] rd_idx = '0;

    logic [FW-1:0] rd_fit;
    logic [FW-1:0] best_energy;
    logic [VW-1:0] best_vec;
    logic [IW-1:0] best_idx;
    logic [CW-1:0] wb_cnt;
    logic          gen_done;
    logic          busy;
    logic          dup_err;
    logic          range_err;

    fitness_wb_collector #(
        .SELF_FIT_LENGTH   (FW),
        .INDIVIDUAL_LENGTH (VW),
        .POP_SIZE          (POP),
        .IDX_WIDTH         (IW),
        .CNT_WIDTH         (CW)
    ) dut (
        .clk_i            (clk),
        .rst_n            (rst_n),
        .gen_start_i      (gen_start),
        .in_valid_i       (in_valid),
        .total_energy_i   (energy),
        .individual_vec_i (vec),
        .ind_idx_i        (idx),
        .rd_idx_i         (rd_idx),
        .rd_fit_ff_o      (rd_fit),
        .best_energy_ff_o (best_energy),
        .best_vec_ff_o    (best_vec),
        .best_idx_ff_o    (best_idx),
        .wb_cnt_ff_o      (wb_cnt),
        .gen_done_ff_o    (gen_done),
        .busy_ff_o        (busy),
        .dup_err_ff_o     (dup_err),
        .range_err_ff_o   (range_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned   due;
        int unsigned   ridx;
        logic [FW-1:0] val;
    } rd_exp_t;

    rd_exp_t     exp_q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          done_pulses = 0;

    // Reference model state
    logic [FW-1:0]  m_rf [POP];
    logic [POP-1:0] m_map;
    int             m_cnt;
    int             m_state;   // 0 idle, 1 collect, 2 done
    logic [FW-1:0]  m_be;
    logic [VW-1:0]  m_bv;
    logic [IW-1:0]  m_bi;
    bit             m_dup;
    bit             m_rng;

    always @(posedge clk) cyc++;

    always @(negedge clk) if (gen_done === 1'b1) done_pulses++;

    // Scoreboard monitor for the read port
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            rd_exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (rd_fit !== e.val) begin
                errors++;
                $display("FAIL rd_fit idx=%0d got %h want %h at t=%0t", e.ridx, rd_fit, e.val, $time);
            end
        end
    end

    task automatic model_reset();
        for (int k = 0; k < POP; k++) m_rf[k] = '0;
        m_map = '0; m_cnt = 0; m_state = 0;
        m_be = '1; m_bv = '0; m_bi = '0; m_dup = 0; m_rng = 0;
    endtask

    // Drive one cycle of stimulus (called at a negedge), queue the predicted read.
    task automatic drive(input bit st, input bit v, input int unsigned i,
                         input logic [FW-1:0] e, input int unsigned r);
        logic [VW-1:0] vv;
        rd_exp_t       x;
        bit            wr;
        vv        = VW'($urandom);
        gen_start = st;
        in_valid  = v;
        idx       = IW'(i);
        energy    = e;
        vec       = vv;
        rd_idx    = IW'(r);
        wr        = !st && (m_state == 1) && v && (i < POP);
        x.due  = cyc + 1;
        x.ridx = r;
        if (r >= POP)           x.val = '1;
        else if (wr && r == i)  x.val = e;
        else                    x.val = m_rf[r];
        exp_q.push_back(x);
        if (st) begin
            m_state = 1; m_map = '0; m_cnt = 0; m_dup = 0; m_rng = 0;
            m_be = '1; m_bv = '0; m_bi = '0;
        end else if (m_state == 1 && v) begin
            if (i >= POP) begin
                m_rng = 1;
            end else begin
                if (m_map[i]) m_dup = 1;
                else begin
                    m_map[i] = 1'b1;
                    m_cnt++;
                    if (m_cnt == POP) m_state = 2;
                end
                m_rf[i] = e;
                if (e < m_be) begin
                    m_be = e; m_bv = vv; m_bi = IW'(i);
                end
            end
        end
        @(negedge clk);
        gen_start = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({rd_fit, best_energy, best_vec, best_idx, wb_cnt, gen_done, busy, dup_err, range_err}
            !== {{FW{1'b0}}, {FW{1'b1}}, {VW{1'b0}}, {IW{1'b0}}, {CW{1'b0}}, 4'b0000}) begin
            errors++;
            $display("FAIL reset_values got fit=%h be=%h bv=%h bi=%0d cnt=%0d d/b/du/r=%b%b%b%b want 0/3ff/0/0/0/0000",
                     rd_fit, best_energy, best_vec, best_idx, wb_cnt, gen_done, busy, dup_err, range_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_gen();
        int p0;
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < POP; i++) begin
            drive(0, 1, i, FW'(100 - i), (i == 0) ? 0 : i - 1);
            if (i == 0) begin
                checks++;
                if (busy !== 1'b1 || gen_done !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_mid got busy=%b done=%b want 1/0", busy, gen_done);
                end
            end
            if (i == POP - 2) p0 = done_pulses;
        end
        checks++;
        if (gen_done !== 1'b1 || busy !== 1'b0 || wb_cnt !== CW'(50)) begin
            errors++;
            $display("FAIL full_gen_done got done=%b busy=%b cnt=%0d want 1/0/50", gen_done, busy, wb_cnt);
        end
        checks++;
        if (best_energy !== FW'(51) || best_idx !== IW'(49) || best_vec !== m_bv) begin
            errors++;
            $display("FAIL full_gen_best got e=%0d i=%0d v=%h want 51/49/%h", best_energy, best_idx, best_vec, m_bv);
        end
        for (int i = 0; i < POP; i++) drive(0, 0, 0, 0, i);
        checks++;
        if (done_pulses - p0 !== 1 || gen_done !== 1'b0) begin
            errors++;
            $display("FAIL gen_done_pulse got pulses=%0d done=%b want 1/0", done_pulses - p0, gen_done);
        end
    endtask

    task automatic test_tie();
        drive(1, 0, 0, 0, 3);
        drive(0, 1, 3, 20, 3);
        drive(0, 1, 7, 20, 7);
        checks++;
        if (best_idx !== IW'(3) || best_energy !== FW'(20) || wb_cnt !== CW'(2) || best_vec !== m_bv) begin
            errors++;
            $display("FAIL tie got idx=%0d e=%0d cnt=%0d want 3/20/2", best_idx, best_energy, wb_cnt);
        end
    endtask

    task automatic test_dup();
        drive(0, 1, 5, 30, 5);
        drive(0, 1, 5, 10, 5);   // read and write same index: write-first
        drive(0, 0, 0, 0, 5);
        checks++;
        if (dup_err !== 1'b1 || wb_cnt !== CW'(3) || best_energy !== FW'(10) || best_idx !== IW'(5)) begin
            errors++;
            $display("FAIL dup got dup=%b cnt=%0d be=%0d bi=%0d want 1/3/10/5", dup_err, wb_cnt, best_energy, best_idx);
        end
    endtask

    task automatic test_range();
        drive(0, 1, 60, 1, 60);
        drive(0, 0, 0, 0, 60);
        checks++;
        if (range_err !== 1'b1 || best_energy !== FW'(10) || wb_cnt !== CW'(3) || rd_fit !== 10'h3FF) begin
            errors++;
            $display("FAIL range got rng=%b be=%0d cnt=%0d fit=%h want 1/10/3/3ff", range_err, best_energy, wb_cnt, rd_fit);
        end
    endtask

    task automatic test_start_collision();
        int p0;
        drive(1, 1, 2, 5, 2);
        checks++;
        if (wb_cnt !== CW'(0) || dup_err !== 1'b0 || range_err !== 1'b0 || best_energy !== 10'h3FF) begin
            errors++;
            $display("FAIL start_collision got cnt=%0d dup=%b rng=%b be=%h want 0/0/0/3ff", wb_cnt, dup_err, range_err, best_energy);
        end
        drive(0, 1, 2, 40, 2);
        checks++;
        if (wb_cnt !== CW'(1) || dup_err !== 1'b0) begin
            errors++;
            $display("FAIL bit2_clear got cnt=%0d dup=%b want 1/0", wb_cnt, dup_err);
        end
        p0 = done_pulses;
        for (int i = 0; i < POP; i++) if (i != 2) drive(0, 1, i, FW'(200 + i), i);
        drive(0, 1, 0, 0, 0);    // in DONE: must be ignored
        drive(0, 0, 0, 0, 0);
        checks++;
        if (wb_cnt !== CW'(m_cnt) || best_energy !== m_be || best_idx !== m_bi || busy !== 1'b0
            || done_pulses - p0 !== 1 || m_state != 2) begin
            errors++;
            $display("FAIL done_ignore got cnt=%0d be=%0d bi=%0d busy=%b pulses=%0d want 50/%0d/%0d/0/1",
                     wb_cnt, best_energy, best_idx, busy, done_pulses - p0, m_be, m_bi);
        end
    endtask

    task automatic test_async_reset();
        int p0;
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) drive(0, 1, i, FW'(300 + i), i);
        checks++;
        if (wb_cnt !== CW'(20)) begin
            errors++;
            $display("FAIL pre_reset_cnt got %0d want 20", wb_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        model_reset();
        checks++;
        if ({rd_fit, best_energy, best_vec, best_idx, wb_cnt, gen_done, busy, dup_err, range_err}
            !== {{FW{1'b0}}, {FW{1'b1}}, {VW{1'b0}}, {IW{1'b0}}, {CW{1'b0}}, 4'b0000}) begin
            errors++;
            $display("FAIL async_reset got fit=%h be=%h bi=%0d cnt=%0d d/b/du/r=%b%b%b%b want 0/3ff/0/0/0000",
                     rd_fit, best_energy, best_idx, wb_cnt, gen_done, busy, dup_err, range_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 1, 1, 0);    // idle after reset: write ignored, RF cleared
        drive(0, 0, 0, 0, 1);
        checks++;
        if (wb_cnt !== CW'(0) || busy !== 1'b0 || best_energy !== 10'h3FF) begin
            errors++;
            $display("FAIL idle_ignore got cnt=%0d busy=%b be=%h want 0/0/3ff", wb_cnt, busy, best_energy);
        end
        p0 = done_pulses;
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < POP; i++) drive(0, 1, POP - 1 - i, FW'($urandom_range(1000, 0)), i);
        drive(0, 0, 0, 0, 0);
        checks++;
        if (done_pulses - p0 !== 1 || wb_cnt !== CW'(50) || best_energy !== m_be || best_idx !== m_bi
            || best_vec !== m_bv) begin
            errors++;
            $display("FAIL regen got pulses=%0d cnt=%0d be=%0d bi=%0d want 1/50/%0d/%0d",
                     done_pulses - p0, wb_cnt, best_energy, best_idx, m_be, m_bi);
        end
    endtask

    initial begin
        test_reset();
        test_full_gen();
        test_tie();
        test_dup();
        test_range();
        test_start_collision();
        test_async_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
